// File: rtl/cga_vram_arbiter.sv
// ==== cga_vram_arbiter : pixel-priority sequencer for the shared CGA video SRAM == rev 1.0 ====
`default_nettype none

module cga_vram_arbiter #(
  parameter logic [18:0] ISA_ADDR_MASK = 19'h07FFF,
  parameter bit          USE_WINDOW    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_read,
  input  logic [18:0] pixel_addr,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  input  logic        isa_op_enable,
  input  logic        isa_read,
  input  logic        isa_write,
  input  logic [18:0] isa_addr,
  input  logic [7:0]  isa_din,
  output logic [7:0]  isa_dout,
  output logic        isa_rdy,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_dout,
  output logic        ram_d_oe,
  input  logic [7:0]  ram_d,
  output logic        collision
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      state;
  logic        pix_pend;
  logic        req;
  logic        window_ok;
  logic [18:0] isa_addr_m;

  assign req        = isa_read | isa_write;
  assign window_ok  = isa_op_enable | ~USE_WINDOW;
  assign isa_addr_m = isa_addr & ISA_ADDR_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pix_pend    <= 1'b0;
      ram_a       <= '0;
      ram_we_l    <= 1'b1;
      ram_d_oe    <= 1'b0;
      ram_dout    <= '0;
      isa_dout    <= '0;
      isa_rdy     <= 1'b1;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      collision   <= 1'b0;
      pix_pend    <= pixel_read;
      pixel_valid <= pix_pend;
      if (pix_pend) begin
        pixel_data <= ram_d;
      end

      case (state)
        IDLE: begin
          // A pending request holds the CPU off even while it waits for the window.
          isa_rdy <= ~req;
          if (!pixel_read && req && window_ok) begin
            ram_a    <= isa_addr_m;
            ram_dout <= isa_din;
            ram_d_oe <= isa_write;
            isa_rdy  <= 1'b0;
            state    <= isa_write ? WR_SETUP : RD;
          end
        end
        RD: begin
          if (!req) begin
            isa_rdy <= 1'b1;
            state   <= IDLE;
          end else if (pixel_read) begin
            collision <= 1'b1;
            state     <= IDLE;
          end else begin
            isa_dout <= ram_d;
            state    <= DONE;
          end
        end
        WR_SETUP: begin
          if (!req) begin
            isa_rdy  <= 1'b1;
            ram_d_oe <= 1'b0;
            state    <= IDLE;
          end else if (pixel_read) begin
            collision <= 1'b1;
            ram_d_oe  <= 1'b0;
            state     <= IDLE;
          end else begin
            ram_we_l <= 1'b0;
            state    <= WR_STROBE;
          end
        end
        WR_STROBE: begin
          // Once the strobe is out the write always completes.
          ram_we_l <= 1'b1;
          ram_d_oe <= 1'b0;
          if (!req) begin
            isa_rdy <= 1'b1;
            state   <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          isa_rdy <= 1'b1;
          if (!req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Pixel fetch owns the RAM bus; it never lands while the write strobe is low.
      if (pixel_read) begin
        ram_a    <= pixel_addr;
        ram_we_l <= 1'b1;
        ram_d_oe <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
